// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package icache_direct_pkg;

   localparam int unsigned ICACHE_INDEX_BITS = 8;
   localparam int unsigned INST_SIZE         = 32;

   typedef enum logic [0:0] {
      IC_IDLE = 1'b0,
      IC_MISS = 1'b1
   } ic_state_e;

   // Clear the byte-offset bits so the address names a whole instruction word.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one combinational read port, one write port.
// Valid bits are flops so they can be cleared by reset; tag/data map to RAM.
module icache_array
   import icache_direct_pkg::*;
#(
   parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
)
(
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [INDEX_BITS-1:0]   rd_index_i,
   output logic                    rd_valid_o,
   output logic [29-INDEX_BITS:0]  rd_tag_o,
   output logic [INST_SIZE-1:0]    rd_data_o,
   input  logic                    wr_en_i,
   input  logic [INDEX_BITS-1:0]   wr_index_i,
   input  logic [29-INDEX_BITS:0]  wr_tag_i,
   input  logic [INST_SIZE-1:0]    wr_data_i
);

   localparam int unsigned LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]          valid_q;
   logic [29-INDEX_BITS:0]    tag_q  [LINES];
   logic [INST_SIZE-1:0]      data_q [LINES];

   // Valid bits: cleared on reset, set by each fill.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_index_i] <= 1'b1;
      end
   end

   // Tag/data arrays: no reset so they can map onto RAM macros.
   always_ff @(posedge clk_in) begin
      if (wr_en_i) begin
         tag_q[wr_index_i]  <= wr_tag_i;
         data_q[wr_index_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache_direct_chk.sv
// Protocol checker: the fetch PC must stay put while a miss is outstanding.
module icache_direct_chk
   import icache_direct_pkg::*;
(
   input logic        clk_i,
   input logic        rst_n_i,
   input logic        miss_i,
   input logic        clear_i,
   input logic [31:0] pc_i,
   input logic [31:0] mem_addr_i
);

   a_pc_stable_in_miss: assert property (
      @(posedge clk_i) disable iff (!rst_n_i)
      (miss_i && !clear_i) |-> (word_align(pc_i) == mem_addr_i)
   );

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the
// memory controller. Hits answer one cycle later; misses fetch one word.
module icache_direct
   import icache_direct_pkg::*;
#(
   parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
)
(
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear,
   input  logic                 if_req_i,
   input  logic [31:0]          if_pc_i,
   output logic                 if_valid_o,
   output logic [INST_SIZE-1:0] if_inst_o,
   output logic                 mem_en_o,
   output logic [31:0]          mem_addr_o,
   input  logic                 mem_valid_i,
   input  logic [INST_SIZE-1:0] mem_data_i
);

   ic_state_e                state_q, state_d;
   logic                     if_valid_q, if_valid_d;
   logic [INST_SIZE-1:0]     if_inst_q, if_inst_d;
   logic [31:0]              mem_addr_q, mem_addr_d;
   logic                     fill_s;
   logic                     wr_en_s;
   logic                     rd_valid_s;
   logic [29-INDEX_BITS:0]   rd_tag_s;
   logic [INST_SIZE-1:0]     rd_data_s;
   logic                     hit_s;

   icache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .rd_index_i (if_pc_i[INDEX_BITS+1:2]),
      .rd_valid_o (rd_valid_s),
      .rd_tag_o   (rd_tag_s),
      .rd_data_o  (rd_data_s),
      .wr_en_i    (wr_en_s),
      .wr_index_i (mem_addr_q[INDEX_BITS+1:2]),
      .wr_tag_i   (mem_addr_q[31:INDEX_BITS+2]),
      .wr_data_i  (mem_data_i)
   );

   icache_direct_chk u_chk (
      .clk_i      (clk_in),
      .rst_n_i    (rst_in),
      .miss_i     (state_q == IC_MISS),
      .clear_i    (clear),
      .pc_i       (if_pc_i),
      .mem_addr_i (mem_addr_q)
   );

   assign hit_s   = rd_valid_s && (rd_tag_s == if_pc_i[31:INDEX_BITS+2]);
   // The fill uses the latched miss address, and a stalled pipeline writes nothing.
   assign wr_en_s = fill_s && rdy_in;

   // Next-state and output decode; clear overrides every request and fill.
   always_comb begin
      state_d    = state_q;
      if_valid_d = 1'b0;
      if_inst_d  = if_inst_q;
      mem_addr_d = mem_addr_q;
      fill_s     = 1'b0;
      if (clear) begin
         state_d = IC_IDLE;
      end else begin
         case (state_q)
            IC_IDLE: begin
               // The cycle after a response is skipped: fetch moves its PC on that edge.
               if (if_req_i && !if_valid_q) begin
                  if (hit_s) begin
                     if_valid_d = 1'b1;
                     if_inst_d  = rd_data_s;
                  end else begin
                     mem_addr_d = word_align(if_pc_i);
                     state_d    = IC_MISS;
                  end
               end else begin
                  state_d = IC_IDLE;
               end
            end
            IC_MISS: begin
               if (mem_valid_i) begin
                  fill_s     = 1'b1;
                  if_valid_d = 1'b1;
                  if_inst_d  = mem_data_i;
                  state_d    = IC_IDLE;
               end else begin
                  state_d = IC_MISS;
               end
            end
            default: begin
               state_d = IC_IDLE;
            end
         endcase
      end
   end

   // Control and output registers; rdy_in low freezes everything.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= IC_IDLE;
         if_valid_q <= 1'b0;
         if_inst_q  <= '0;
         mem_addr_q <= 32'h0000_0000;
      end else if (rdy_in) begin
         state_q    <= state_d;
         if_valid_q <= if_valid_d;
         if_inst_q  <= if_inst_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   // The request drops in the completion cycle so the controller never refetches.
   assign mem_en_o   = (state_q == IC_MISS) && !mem_valid_i;
   assign if_valid_o = if_valid_q;
   assign if_inst_o  = if_inst_q;
   assign mem_addr_o = mem_addr_q;

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the fetch stage (upstream) and the memory controller's instruction port (downstream).
- Hits return an instruction one cycle after the request.
- Misses issue a single 4-byte fetch to the memory controller, fill the line, and return the word.
- `clear` abandons any in-flight miss on pipeline flush; cache contents are preserved.

Parameters:
- INDEX_BITS, 8, log2 of line count (256 lines x 32 bit). Tag width = 30 - INDEX_BITS.

Ports:
- clk_in  input  1  system clock, rising edge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global ready; when low, all state holds
- clear  input  1  synchronous flush of in-flight request (mispredict)
- if_req_i  input  1  fetch stage requests instruction at if_pc_i (level; held until if_valid_o)
- if_pc_i  input  32  instruction address, bits[1:0] ignored
- if_valid_o  output  1  one-cycle pulse: if_inst_o valid for current request
- if_inst_o  output  32  instruction word
- mem_en_o  output  1  fetch request to memory controller
- mem_addr_o  output  32  word-aligned fetch address
- mem_valid_i  input  1  one-cycle pulse: mem_data_i holds the fetched word
- mem_data_i  input  32  fetched little-endian word

Behaviour:
- Reset (rst_in low, async):
  - All valid bits cleared; state IDLE.
  - if_valid_o=0, if_inst_o=0, mem_addr_o=0.
  - Tag/data arrays need no reset.
- rdy_in low: no register changes; mem_en_o keeps its value.
- Address split: index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2].
- State IDLE:
  - if_req_i & ~if_valid_o & hit (valid[index] & tag match): next cycle if_valid_o=1, if_inst_o=data[index]; stay IDLE. Hit latency 1 cycle.
  - if_req_i & miss: latch pc (word-aligned) into mem_addr_o; go MISS.
  - The cycle after an if_valid_o pulse is never treated as a new request. The fetch stage updates the PC in the same edge, so the back-to-back hit rate is one instruction per 2 cycles.
- State MISS:
  - mem_en_o = (state==MISS) & ~mem_valid_i (combinational). The request drops in the completion cycle, so the memory controller, back in its idle state on the next edge, does not start a duplicate fetch.
  - On mem_valid_i: write data[index]=mem_data_i, tag, valid=1. Next cycle if_valid_o=1, if_inst_o=mem_data_i. Return to IDLE.
  - Miss latency = controller latency (6 cycles from mem_en_o rising) + 1.
- if_valid_o is a single-cycle pulse, cleared on every cycle it is not set.
- clear (synchronous, priority over everything except reset):
  - State to IDLE; if_valid_o=0; no fill occurs. A mem_valid_i arriving in the same cycle as clear is discarded.
  - The memory controller is cleared by the same signal, so no stale response follows.
- Fetch stage changes if_pc_i while in MISS (not legal without clear): undefined; assertion flags it.
- Simultaneous if_req_i and clear: clear wins; the request is re-evaluated the next cycle.
- Addresses of different tags, same index: the later fill overwrites; no associativity.

Decomposition:
- Shared def.v gains:
  - ICache state encodings `IC_Idle`, `IC_Miss`.
  - `ICacheIndexBits` default.
  - Reuse of `InstSize`.
- One natural sub-module: icache_array (valid/tag/data storage, one combinational read port, one write port). Valid bits use flops with async reset; tag/data are inferable RAM.

Test Plan:
- Reset then req pc=0x0000_0000, memory word 0x0000_0513 → mem_en_o rises at cycle 1, mem_addr_o=0x0; mem_valid_i at cycle 6 → if_valid_o pulse cycle 7, if_inst_o=0x0000_0513; mem_en_o low in cycle 6.
- Re-request pc=0x0 → if_valid_o after exactly 1 cycle, mem_en_o never asserted.
- Conflict: fill 0x0004, then pc=0x0404 (INDEX_BITS=8, same index) → miss, refill. Then 0x0004 → miss again.
- clear asserted during MISS, 3 cycles after mem_en_o → state IDLE, no if_valid_o, line stays invalid. Next req same pc misses again.
- mem_valid_i coincident with clear → no fill, no if_valid_o; subsequent req misses.
- rdy_in low for 4 cycles mid-miss, with mem_valid_i held off → outputs frozen; completes normally after rdy_in returns; async reset mid-miss → all outputs 0 immediately, mem_en_o 0.
